// File: rtl/pipeline_ctrl.sv
// Pipeline hazard and data-memory stall controller: load-use and branch hazards, memory-wait
// stalls with a timeout abort, and a saturating stall-cycle counter.
module pipeline_ctrl #(
   parameter logic [7:0]  TIMEOUT = 8'd255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic [4:0]       ID_EX_rd,
   input  logic             ID_EX_memread,
   input  logic             EX_pc_src,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushW,
   output logic             mem_abort,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [0:0] {StRun, StMwait} state_e;

   state_e           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic lu, ms, tmo;

   assign lu = ID_EX_memread && (ID_EX_rd != 5'd0) &&
               ((ID_EX_rd == ID_rs1) || (ID_EX_rd == ID_rs2));

   always_comb begin
      ms  = 1'b0;
      tmo = 1'b0;
      if (state_q == StRun) begin
         ms = dmem_req && !dmem_ack;
      end else begin
         ms  = !dmem_ack && (wait_cnt_q != TIMEOUT);
         tmo = !dmem_ack && (wait_cnt_q == TIMEOUT);
      end
   end

   // Outputs are Mealy, but held low for as long as reset is asserted.
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      mem_abort = 1'b0;
      if (rst) begin
         if (ms) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (tmo) begin
            // Abandoned access: bubble MEM_WB; a taken branch still squashes the front end.
            flushW    = 1'b1;
            mem_abort = 1'b1;
            flushD    = EX_pc_src;
            flushE    = EX_pc_src;
         end else if (EX_pc_src) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (lu) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;
      unique case (state_q)
         StRun: begin
            if (dmem_req && !dmem_ack) begin
               state_d    = StMwait;
               wait_cnt_d = 8'd1;
            end
         end
         StMwait: begin
            if (dmem_ack) begin
               state_d    = StRun;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == TIMEOUT) begin
               state_d    = StRun;
               wait_cnt_d = 8'd0;
               mem_err_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = StRun;
      endcase
      if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, memory wait, timeout abort, counter, reset.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ID_rs1, ID_rs2, ID_EX_rd;
   logic        ID_EX_memread, EX_pc_src, dmem_req, dmem_ack;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_abort, mem_err;
   logic [15:0] stall_cnt;
   logic        s2F, s2D, s2E, s2M, f2D, f2E, f2W, abort2, err2;
   logic [1:0]  cnt2;
   logic [7:0]  ctl;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   // {stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_abort}
   assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_abort};

   localparam logic [7:0] CtlIdle = 8'b0000_0000;
   localparam logic [7:0] CtlLu   = 8'b1100_0100;
   localparam logic [7:0] CtlBr   = 8'b0000_1100;
   localparam logic [7:0] CtlMs   = 8'b1111_0010;
   localparam logic [7:0] CtlAbt  = 8'b0000_0011;

   always #5 clk = ~clk;

   pipeline_ctrl #(.TIMEOUT(8'd4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_EX_rd(ID_EX_rd),
      .ID_EX_memread(ID_EX_memread), .EX_pc_src(EX_pc_src), .dmem_req(dmem_req),
      .dmem_ack(dmem_ack), .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
      .mem_abort(mem_abort), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   // Narrow counter instance used only to observe saturation.
   pipeline_ctrl #(.TIMEOUT(8'd255), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_EX_rd(ID_EX_rd),
      .ID_EX_memread(ID_EX_memread), .EX_pc_src(EX_pc_src), .dmem_req(dmem_req),
      .dmem_ack(dmem_ack), .stallF(s2F), .stallD(s2D), .stallE(s2E),
      .stallM(s2M), .flushD(f2D), .flushE(f2E), .flushW(f2W),
      .mem_abort(abort2), .mem_err(err2), .stall_cnt(cnt2)
   );

   task automatic idle_inputs();
      ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
      ID_EX_memread = 1'b0; EX_pc_src = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ID_rs1 = 5'd7; ID_rs2 = 5'd7; ID_EX_rd = 5'd7; ID_EX_memread = 1'b1;
      EX_pc_src = 1'b1; dmem_req = 1'b1; dmem_ack = 1'b0;
      #12;
      checks++;
      if (ctl !== CtlIdle) begin
         failures++; $display("FAIL reset_ctl: got %b expected %b", ctl, CtlIdle);
      end
      checks++;
      if (stall_cnt !== 16'd0 || mem_err !== 1'b0) begin
         failures++; $display("FAIL reset_regs: got cnt=%0d err=%b expected cnt=0 err=0",
                              stall_cnt, mem_err);
      end
      idle_inputs();
      #1 rst = 1'b1;
      tick();
      exp_cnt = 0;
      checks++;
      if (ctl !== CtlIdle || stall_cnt !== 16'd0) begin
         failures++; $display("FAIL post_reset_idle: got ctl=%b cnt=%0d expected %b cnt=0",
                              ctl, stall_cnt, CtlIdle);
      end
   endtask

   task automatic test_load_use();
      ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs1 = 5'd3; ID_rs2 = 5'd5;
      #1;
      checks++;
      if (ctl !== CtlLu) begin
         failures++; $display("FAIL load_use_ctl: got %b expected %b", ctl, CtlLu);
      end
      tick();
      exp_cnt++;
      idle_inputs();
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         failures++; $display("FAIL load_use_release: got %b expected %b", ctl, CtlIdle);
      end
      checks++;
      if (stall_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
      end
      // rs1 match also counts as a hazard
      ID_EX_memread = 1'b1; ID_EX_rd = 5'd17; ID_rs1 = 5'd17; ID_rs2 = 5'd2;
      #1;
      checks++;
      if (ctl !== CtlLu) begin
         failures++; $display("FAIL load_use_rs1: got %b expected %b", ctl, CtlLu);
      end
      tick();
      exp_cnt++;
      idle_inputs();
   endtask

   task automatic test_rd_zero();
      ID_EX_memread = 1'b1; ID_EX_rd = 5'd0; ID_rs1 = 5'd0; ID_rs2 = 5'd0;
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         failures++; $display("FAIL rd_zero_ctl: got %b expected %b", ctl, CtlIdle);
      end
      tick();
      // not a load: no hazard even with matching indices
      ID_EX_memread = 1'b0; ID_EX_rd = 5'd9; ID_rs1 = 5'd9;
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         failures++; $display("FAIL non_load_ctl: got %b expected %b", ctl, CtlIdle);
      end
      tick();
      checks++;
      if (stall_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL rd_zero_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
      end
      idle_inputs();
   endtask

   task automatic test_branch_priority();
      ID_EX_memread = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5; EX_pc_src = 1'b1;
      #1;
      checks++;
      if (ctl !== CtlBr) begin
         failures++; $display("FAIL branch_over_lu: got %b expected %b", ctl, CtlBr);
      end
      tick();
      idle_inputs();
      EX_pc_src = 1'b1;
      #1;
      checks++;
      if (ctl !== CtlBr) begin
         failures++; $display("FAIL branch_only: got %b expected %b", ctl, CtlBr);
      end
      tick();
      idle_inputs();
      checks++;
      if (stall_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL branch_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_mem_wait();
      dmem_req = 1'b1; dmem_ack = 1'b1;
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         failures++; $display("FAIL ack_in_run: got %b expected %b", ctl, CtlIdle);
      end
      tick();
      dmem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         EX_pc_src = (i == 1);
         ID_EX_memread = (i == 2); ID_EX_rd = 5'd4; ID_rs1 = 5'd4;
         #1;
         checks++;
         if (ctl !== CtlMs) begin
            failures++; $display("FAIL mem_wait_cyc%0d: got %b expected %b", i, ctl, CtlMs);
         end
         tick();
         exp_cnt++;
      end
      idle_inputs();
      dmem_req = 1'b1; dmem_ack = 1'b1;
      #1;
      checks++;
      if (ctl !== CtlIdle) begin
         failures++; $display("FAIL mem_ack_cycle: got %b expected %b", ctl, CtlIdle);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (ctl !== CtlIdle || stall_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL mem_wait_done: got ctl=%b cnt=%0d expected %b cnt=%0d",
                              ctl, stall_cnt, CtlIdle, exp_cnt);
      end
      // back in RUN, a load-use hazard must behave normally
      ID_EX_memread = 1'b1; ID_EX_rd = 5'd6; ID_rs2 = 5'd6;
      #1;
      checks++;
      if (ctl !== CtlLu) begin
         failures++; $display("FAIL mem_wait_back_run: got %b expected %b", ctl, CtlLu);
      end
      tick();
      exp_cnt++;
      idle_inputs();
   endtask

   task automatic test_saturation();
      checks++;
      if (cnt2 !== 2'd3) begin
         failures++; $display("FAIL cnt_saturate: got %0d expected 3", cnt2);
      end
   endtask

   task automatic test_timeout();
      dmem_req = 1'b1; dmem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (ctl !== CtlMs) begin
            failures++; $display("FAIL timeout_wait%0d: got %b expected %b", i, ctl, CtlMs);
         end
         tick();
         exp_cnt++;
      end
      dmem_req = 1'b0;
      #1;
      checks++;
      if (ctl !== CtlAbt || mem_err !== 1'b0) begin
         failures++; $display("FAIL timeout_abort: got ctl=%b err=%b expected %b err=0",
                              ctl, mem_err, CtlAbt);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ctl !== CtlIdle || mem_err !== 1'b1) begin
            failures++; $display("FAIL timeout_after%0d: got ctl=%b err=%b expected %b err=1",
                                 i, ctl, mem_err, CtlIdle);
         end
         tick();
      end
      checks++;
      if (stall_cnt !== 16'(exp_cnt)) begin
         failures++; $display("FAIL timeout_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset_in_wait();
      dmem_req = 1'b1; dmem_ack = 1'b0;
      tick();
      tick();
      exp_cnt += 2;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ctl !== CtlIdle || mem_err !== 1'b0 || stall_cnt !== 16'd0) begin
         failures++; $display("FAIL reset_in_wait: got ctl=%b err=%b cnt=%0d expected %b 0 0",
                              ctl, mem_err, stall_cnt, CtlIdle);
      end
      idle_inputs();
      tick();
      #1 rst = 1'b1;
      tick();
      checks++;
      if (ctl !== CtlIdle || mem_err !== 1'b0 || stall_cnt !== 16'd0) begin
         failures++; $display("FAIL after_reset_run: got ctl=%b err=%b cnt=%0d expected %b 0 0",
                              ctl, mem_err, stall_cnt, CtlIdle);
      end
      EX_pc_src = 1'b1;
      #1;
      checks++;
      if (ctl !== CtlBr) begin
         failures++; $display("FAIL after_reset_branch: got %b expected %b", ctl, CtlBr);
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_load_use();
      test_rd_zero();
      test_branch_priority();
      test_mem_wait();
      test_saturation();
      test_timeout();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
